// File: rtl/shift_add_multiplier.sv
// Sequential 32x32 unsigned shift-add multiplier around a single 32-bit adder.
// One bit of the multiplier is retired per cycle; the 64-bit product lands after 32 iterations.

module Thirty_Two_Bit_Full_Adder (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] s,
  output logic        c31
);

  logic [32:0] cy;

  always_comb begin
    cy    = '0;
    s     = '0;
    cy[0] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      s[i]    = x[i] ^ y[i] ^ cy[i];
      cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
    end
    c31 = cy[32];
  end

endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_y;
  logic [WIDTH-1:0]   add_s;
  logic               add_c;

  assign add_y = lo_q[0] ? mcand_q : '0;

  Thirty_Two_Bit_Full_Adder u_add (
    .x   (hi_q),
    .y   (add_y),
    .s   (add_s),
    .c31 (add_c)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // carry out becomes the new top bit, so the 65-bit sum never overflows
        hi_d    = {add_c, add_s[WIDTH-1:1]};
        lo_d    = {add_s[0], lo_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          state_d   = S_DONE;
          product_d = {hi_d, lo_d};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: latency, product values,
// ignored start, async abort and back-to-back issue.

module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks;
  int failures;
  int cyc_ctr;

  shift_add_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_ctr++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Drives start for one edge (E0) and returns #1 after E0.
  task automatic issue(input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    a = aa;
    b = bb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles from E0 until done is seen; busy samples include the one at E0.
  task automatic wait_done(output int cyc, output int bcnt, output logic [63:0] prod,
                           output bit to);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    prod = 'x;
    to   = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc  = i;
        prod = product;
        to   = 1'b0;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || product !== 64'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b product=%h want 0 0 0",
               busy, done, product);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int cyc, bcnt;
    logic [63:0] p;
    bit to;
    issue(32'd3, 32'd5);
    wait_done(cyc, bcnt, p, to);
    checks++;
    if (to || cyc !== 32) begin
      failures++;
      $display("FAIL basic_latency: done at %0d timeout=%0b want 32", cyc, to);
    end
    checks++;
    if (bcnt !== 32) begin
      failures++;
      $display("FAIL basic_busy: busy cycles=%0d want 32", bcnt);
    end
    checks++;
    if (p !== 64'd15) begin
      failures++;
      $display("FAIL basic_product: got %h want %h", p, 64'd15);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: done=%0b want 0", done);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (product !== 64'd15 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold: product=%h busy=%0b want 15 0", product, busy);
    end
  endtask

  task automatic test_max;
    int cyc, bcnt;
    logic [63:0] p;
    bit to;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bcnt, p, to);
    checks++;
    if (to || p !== 64'hFFFF_FFFE_0000_0001) begin
      failures++;
      $display("FAIL max_product: got %h timeout=%0b want fffffffe00000001", p, to);
    end
  endtask

  task automatic test_zero;
    int cyc, bcnt;
    logic [63:0] p;
    bit to;
    issue(32'h1234_5678, 32'd0);
    wait_done(cyc, bcnt, p, to);
    checks++;
    if (to || cyc !== 32 || p !== 64'd0) begin
      failures++;
      $display("FAIL zero_b: product=%h done_at=%0d want 0 at 32", p, cyc);
    end
    issue(32'd0, 32'hDEAD_BEEF);
    wait_done(cyc, bcnt, p, to);
    checks++;
    if (to || cyc !== 32 || p !== 64'd0) begin
      failures++;
      $display("FAIL zero_a: product=%h done_at=%0d want 0 at 32", p, cyc);
    end
  endtask

  task automatic test_ignore_start;
    int ndone, first;
    logic [63:0] p;
    issue(32'd7, 32'd9);
    ndone = 0;
    first = 0;
    p = '0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = i;
          p = product;
        end
      end
      if (i == 10) begin
        a = 32'd100;
        b = 32'd100;
        start = 1'b1;
      end
      if (i == 11) start = 1'b0;
    end
    checks++;
    if (ndone !== 1 || first !== 32) begin
      failures++;
      $display("FAIL ignore_done: count=%0d first=%0d want 1 at 32", ndone, first);
    end
    checks++;
    if (p !== 64'd63) begin
      failures++;
      $display("FAIL ignore_product: got %h want %h", p, 64'd63);
    end
  endtask

  task automatic test_abort;
    int cyc, bcnt, nd;
    logic [63:0] p;
    bit to;
    issue(32'd1000, 32'd1000);
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || product !== 64'd0) begin
      failures++;
      $display("FAIL abort_async: busy=%0b done=%0b product=%h want 0 0 0",
               busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL abort_no_done: active cycles=%0d want 0", nd);
    end
    issue(32'd2, 32'd21);
    wait_done(cyc, bcnt, p, to);
    checks++;
    if (to || p !== 64'd42) begin
      failures++;
      $display("FAIL abort_restart: got %h timeout=%0b want %h", p, to, 64'd42);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] oa [3];
    logic [31:0] ob [3];
    logic [63:0] exp_p [3];
    int t_prev, t_now;
    bit seen;
    oa[0] = 32'd6;          ob[0] = 32'd7;      exp_p[0] = 64'd42;
    oa[1] = 32'd65536;      ob[1] = 32'd65536;  exp_p[1] = 64'h1_0000_0000;
    oa[2] = 32'h8000_0000;  ob[2] = 32'd2;      exp_p[2] = 64'h1_0000_0000;
    t_prev = 0;
    @(negedge clk);
    a = oa[0];
    b = ob[0];
    start = 1'b1;
    @(posedge clk);
    #1;
    a = oa[1];
    b = ob[1];
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      t_now = cyc_ctr;
      checks++;
      if (!seen || product !== exp_p[k]) begin
        failures++;
        $display("FAIL b2b_product%0d: got %h seen=%0b want %h",
                 k, product, seen, exp_p[k]);
      end
      if (k > 0) begin
        checks++;
        if (t_now - t_prev !== 33) begin
          failures++;
          $display("FAIL b2b_spacing%0d: got %0d want 33", k, t_now - t_prev);
        end
      end
      t_prev = t_now;
      if (k < 2) begin
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_reissue%0d: done=%0b busy=%0b want 0 1", k, done, busy);
        end
        if (k == 0) begin
          a = oa[2];
          b = ob[2];
        end else begin
          start = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_idle: busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc_ctr = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
